// File: rtl/keccak_share_compress.sv
// Registers the SHARES**2-share chi/iota output, XOR-compresses it to SHARES shares; 2-cycle latency.
// Two-entry elastic valid/ready pipe: full only when both stages hold data and the consumer stalls.
module keccak_share_compress #(
  parameter int SHARES = 2,
  parameter int W      = 8
) (
  input  logic                           ClkxCI,
  input  logic                           RstxRBI,
  input  logic [SHARES*SHARES*25*W-1:0]  InxDI,
  input  logic                           InValidxSI,
  output logic                           InReadyxSO,
  input  logic                           InLastxSI,
  output logic [SHARES*25*W-1:0]         OutxDO,
  output logic                           OutValidxSO,
  input  logic                           OutReadyxSI,
  output logic                           OutLastxSO,
  output logic [4:0]                     RoundCntxDO
);

  localparam int SHARE_W = 25 * W;
  localparam int EXP_W   = SHARES * SHARES * SHARE_W;
  localparam int OUT_W   = SHARES * SHARE_W;

  logic [EXP_W-1:0] a_data;
  logic             a_vld;
  logic             a_last;
  logic [OUT_W-1:0] b_data;
  logic             b_vld;
  logic             b_last;
  logic [OUT_W-1:0] comp;
  logic [4:0]       round_cnt;
  logic             b_rdy;
  logic             a_load;
  logic             b_load;
  logic             out_xfer;

  assign b_rdy      = !b_vld | OutReadyxSI;
  assign InReadyxSO = !a_vld | b_rdy;
  assign a_load     = InValidxSI & InReadyxSO;
  assign b_load     = a_vld & b_rdy;
  assign out_xfer   = b_vld & OutReadyxSI;

  // Compression only ever sees the registered expanded shares, never InxDI directly.
  always_comb begin
    comp = '0;
    for (int j = 0; j < SHARES; j++) begin
      for (int k = 0; k < SHARES; k++) begin
        comp[j*SHARE_W +: SHARE_W] = comp[j*SHARE_W +: SHARE_W]
                                   ^ a_data[(j*SHARES+k)*SHARE_W +: SHARE_W];
      end
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxRBI) begin
    if (!RstxRBI) begin
      a_data <= '0;
      a_last <= 1'b0;
      a_vld  <= 1'b0;
    end else if (a_load) begin
      a_data <= InxDI;
      a_last <= InLastxSI;
      a_vld  <= 1'b1;
    end else if (b_load) begin
      a_vld  <= 1'b0;
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxRBI) begin
    if (!RstxRBI) begin
      b_data <= '0;
      b_last <= 1'b0;
      b_vld  <= 1'b0;
    end else if (b_load) begin
      b_data <= comp;
      b_last <= a_last;
      b_vld  <= 1'b1;
    end else if (out_xfer) begin
      b_vld  <= 1'b0;
    end
  end

  // Beat index within the permutation; the last-tagged beat restarts the count.
  always_ff @(posedge ClkxCI or negedge RstxRBI) begin
    if (!RstxRBI) begin
      round_cnt <= 5'd0;
    end else if (out_xfer) begin
      round_cnt <= b_last ? 5'd0 : round_cnt + 5'd1;
    end
  end

  assign OutxDO      = b_data;
  assign OutValidxSO = b_vld;
  assign OutLastxSO  = b_last;
  assign RoundCntxDO = round_cnt;

endmodule
